// File: rtl/vector_serializer.sv
// vector_serializer: 8-bit parallel-to-serial shifter with gapless frame chaining.
// Define VECTOR_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module vector_serializer #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          LSB_FIRST    = 1'b0,
  parameter bit          IDLE_LEVEL   = 1'b0
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iVector,
  input  logic       iLoad,
  output logic       oSignal,
  output logic       oReady,
  output logic       oBusy,
  output logic       oDone
);

  localparam int unsigned DATA_W = 8;
`ifdef VECTOR_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_W + 1;
`else
  localparam int unsigned FRAME_BITS = DATA_W;
`endif
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_div_cnt;
  logic               r_signal;
  logic               r_done;
  logic               w_bit_end;
  logic               w_frame_end;
  logic               w_ready;
  logic               w_load;
  logic               w_first_bit;
  logic               w_next_bit;
`ifdef VECTOR_SERIALIZER_PARITY_EN
  logic               r_parity;
`endif

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a load in the last clock of a frame keeps the FSM in SHIFT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_frame_end && !w_load) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame timing decodes and load handshake
  always_comb begin
    w_bit_end   = 1'b0;
    w_frame_end = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
      end
      S_SHIFT: begin
        w_bit_end   = (r_div_cnt == DIV_LAST);
        w_frame_end = w_bit_end && (r_bit_cnt == BIT_LAST);
        w_ready     = w_frame_end;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
    w_load = iLoad && w_ready;
  end

  // Bit selection for the first bit of a new frame and for each following boundary
  always_comb begin
    w_first_bit = LSB_FIRST ? iVector[0] : iVector[DATA_W-1];
    w_next_bit  = LSB_FIRST ? r_shift[1] : r_shift[DATA_W-2];
`ifdef VECTOR_SERIALIZER_PARITY_EN
    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
      w_next_bit = r_parity;
    end
`endif
  end

  // Datapath: shift register, counters and registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_signal  <= IDLE_LEVEL;
      r_done    <= 1'b0;
`ifdef VECTOR_SERIALIZER_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= w_frame_end;
      if (w_load) begin
        r_shift   <= iVector;
        r_bit_cnt <= '0;
        r_div_cnt <= '0;
        r_signal  <= w_first_bit;
`ifdef VECTOR_SERIALIZER_PARITY_EN
        r_parity  <= ^iVector;
`endif
      end else if (w_frame_end) begin
        r_bit_cnt <= '0;
        r_div_cnt <= '0;
        r_signal  <= IDLE_LEVEL;
      end else if (w_bit_end) begin
        r_div_cnt <= '0;
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_shift   <= LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
        r_signal  <= w_next_bit;
      end else if (r_state == S_SHIFT) begin
        r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
    end
  end

  assign oSignal = r_signal;
  assign oReady  = w_ready;
  assign oBusy   = (r_state == S_SHIFT);
  assign oDone   = r_done;

endmodule
